// File: rtl/gpio_stim_pkg.sv
// Shared types for the GPIO stimulus generator: event modes, channel states
// and the per-channel configuration record.
package gpio_stim_pkg;

    // Widest counter field the config record can carry; channels use the low CNT_W bits.
    localparam int unsigned StimCntMaxW = 32;

    typedef enum logic [1:0] {
        ModeToggle = 2'd0,
        ModePulse  = 2'd1,
        ModeHold   = 2'd2
    } stim_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRun,
        StDone
    } stim_state_e;

    typedef struct packed {
        logic                   en;
        logic                   init;
        stim_mode_e             mode;
        logic [StimCntMaxW-1:0] delay;
        logic [StimCntMaxW-1:0] period;
        logic [StimCntMaxW-1:0] count;
    } stim_cfg_t;

    // The reserved encoding behaves as HOLD.
    function automatic stim_mode_e decode_mode(logic [1:0] raw);
        return (raw == 2'd3) ? ModeHold : stim_mode_e'(raw);
    endfunction

endpackage

// File: rtl/gpio_stim_ch.sv
// One stimulus channel: config registers, IDLE/DELAY/RUN/DONE sequencer,
// period timer and the registered output level.
module gpio_stim_ch
    import gpio_stim_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  stim_cfg_t   cfg_i,
    input  logic        start_i,
    input  logic        stop_i,
    output logic        gpio_o,
    output logic        en_o,
    output stim_state_e state_o
);

    stim_state_e      state_q;
    stim_mode_e       mode_q;
    logic             en_q, init_q, gpio_q;
    logic [CNT_W-1:0] delay_q, period_q, count_q, timer_q, remain_q;
    logic [CNT_W-1:0] reload;
    logic             can_cfg;

    // Period 0 behaves as period 1, so the timer reload never underflows.
    assign reload  = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign can_cfg = (state_q == StIdle) || (state_q == StDone);

    if (CNT_W < StimCntMaxW) begin : g_unused_hi
        logic unused_cfg_hi;
        assign unused_cfg_hi = ^{cfg_i.delay[StimCntMaxW-1:CNT_W],
                                 cfg_i.period[StimCntMaxW-1:CNT_W],
                                 cfg_i.count[StimCntMaxW-1:CNT_W]};
    end

    // Channel sequencer: stop beats config write, which beats start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            mode_q   <= ModeToggle;
            en_q     <= 1'b0;
            init_q   <= 1'b0;
            gpio_q   <= 1'b0;
            delay_q  <= '0;
            period_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            remain_q <= '0;
        end else if (stop_i) begin
            state_q <= StIdle;
            gpio_q  <= init_q;
        end else if (we_i && can_cfg) begin
            state_q  <= StIdle;
            en_q     <= cfg_i.en;
            init_q   <= cfg_i.init;
            mode_q   <= cfg_i.mode;
            delay_q  <= cfg_i.delay[CNT_W-1:0];
            period_q <= cfg_i.period[CNT_W-1:0];
            count_q  <= cfg_i.count[CNT_W-1:0];
            gpio_q   <= cfg_i.init;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // A pulse issued by the final event lasts one cycle only.
                    if (state_q == StDone && mode_q == ModePulse) gpio_q <= init_q;
                    if (start_i && en_q) begin
                        gpio_q <= init_q;
                        if (count_q == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q  <= StDelay;
                            timer_q  <= delay_q;
                            remain_q <= count_q;
                        end
                    end
                end
                StDelay: begin
                    if (timer_q == '0) begin
                        state_q <= StRun;
                        timer_q <= reload;
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                    end
                end
                StRun: begin
                    if (timer_q == '0) begin
                        timer_q  <= reload;
                        remain_q <= remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) state_q <= StDone;
                        unique case (mode_q)
                            ModeToggle: gpio_q <= ~gpio_q;
                            default:    gpio_q <= ~init_q;
                        endcase
                    end else begin
                        timer_q <= timer_q - CNT_W'(1);
                        if (mode_q == ModePulse) gpio_q <= init_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gpio_o  = gpio_q;
    assign en_o    = en_q;
    assign state_o = state_q;

endmodule

// File: rtl/gpio_stim_gen.sv
// Multi-channel GPIO stimulus generator: config decode, CH_NUM channel
// instances, busy/done aggregation and an optional pin-edge monitor.
// Define GPIO_STIM_MON_EN to build the monitor; otherwise mon_cnt_o is 0.
module gpio_stim_gen
    import gpio_stim_pkg::*;
#(
    parameter int unsigned CH_NUM = 16,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned ChW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_we_i,
    input  logic [ChW-1:0]          cfg_ch_i,
    input  logic                    cfg_en_i,
    input  logic                    cfg_init_i,
    input  logic [1:0]              cfg_mode_i,
    input  logic [CNT_W-1:0]        cfg_delay_i,
    input  logic [CNT_W-1:0]        cfg_period_i,
    input  logic [CNT_W-1:0]        cfg_count_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    output logic [CH_NUM-1:0]       gpio_o,
    output logic [CH_NUM-1:0]       done_o,
    output logic                    busy_o,
    output logic                    all_done_o,
    input  logic [CH_NUM-1:0]       gpio_i,
    output logic [CH_NUM*CNT_W-1:0] mon_cnt_o
);

    stim_cfg_t         cfg_wr;
    logic [CH_NUM-1:0] ch_we;
    logic [CH_NUM-1:0] ch_en;
    stim_state_e       ch_state [CH_NUM];
    logic              ch_ok;

    assign ch_ok = {1'b0, cfg_ch_i} < (ChW + 1)'(CH_NUM);

    // Decode the write into one shared record plus a per-channel strobe.
    always_comb begin
        cfg_wr        = '0;
        cfg_wr.en     = cfg_en_i;
        cfg_wr.init   = cfg_init_i;
        cfg_wr.mode   = decode_mode(cfg_mode_i);
        cfg_wr.delay  = StimCntMaxW'(cfg_delay_i);
        cfg_wr.period = StimCntMaxW'(cfg_period_i);
        cfg_wr.count  = StimCntMaxW'(cfg_count_i);
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            ch_we[i] = cfg_we_i && ch_ok && (cfg_ch_i == ChW'(i));
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        gpio_stim_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .we_i    (ch_we[g]),
            .cfg_i   (cfg_wr),
            .start_i (start_i),
            .stop_i  (stop_i),
            .gpio_o  (gpio_o[g]),
            .en_o    (ch_en[g]),
            .state_o (ch_state[g])
        );
    end

    // Status straight from channel state, no added latency.
    always_comb begin
        logic any_en, en_all_done;
        any_en      = 1'b0;
        en_all_done = 1'b1;
        busy_o      = 1'b0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            done_o[i] = (ch_state[i] == StDone);
            if (ch_state[i] == StDelay || ch_state[i] == StRun) busy_o = 1'b1;
            if (ch_en[i]) begin
                any_en = 1'b1;
                if (ch_state[i] != StDone) en_all_done = 1'b0;
            end
        end
        all_done_o = any_en && en_all_done;
    end

`ifdef GPIO_STIM_MON_EN
    logic [CH_NUM-1:0] sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0]  mon_q [CH_NUM];

    // Two-flop synchroniser plus one stage to spot edges.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Saturating both-edge counters, cleared by start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < CH_NUM; i++) mon_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (start_i) begin
                    mon_q[i] <= '0;
                end else if ((sync2_q[i] ^ prev_q[i]) && (mon_q[i] != '1)) begin
                    mon_q[i] <= mon_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        mon_cnt_o = '0;
        for (int unsigned i = 0; i < CH_NUM; i++) mon_cnt_o[i*CNT_W +: CNT_W] = mon_q[i];
    end
`else
    logic unused_gpio_i;
    assign unused_gpio_i = ^gpio_i;
    assign mon_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_gpio_stim_gen.sv
// Directed bench for gpio_stim_gen; gpio_o is looped back to gpio_i so the
// monitor build can be checked by the same stimulus.
module tb_gpio_stim_gen;

    localparam int unsigned CH_NUM = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned VW     = CH_NUM * CNT_W;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              cfg_we, cfg_en, cfg_init, start, stop;
    logic [3:0]        cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_delay, cfg_period, cfg_count;
    logic [CH_NUM-1:0] gpio, done;
    logic              busy, all_done;
    logic [VW-1:0]     mon_cnt;
    logic [VW-1:0]     mon_exp;

    int n_vec = 0;
    int n_err = 0;
    int bad_k;

    always #5 clk = ~clk;

    gpio_stim_gen #(
        .CH_NUM (CH_NUM),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cfg_we_i     (cfg_we),
        .cfg_ch_i     (cfg_ch),
        .cfg_en_i     (cfg_en),
        .cfg_init_i   (cfg_init),
        .cfg_mode_i   (cfg_mode),
        .cfg_delay_i  (cfg_delay),
        .cfg_period_i (cfg_period),
        .cfg_count_i  (cfg_count),
        .start_i      (start),
        .stop_i       (stop),
        .gpio_o       (gpio),
        .done_o       (done),
        .busy_o       (busy),
        .all_done_o   (all_done),
        .gpio_i       (gpio),
        .mon_cnt_o    (mon_cnt)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge; drive and sample there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int ch, input logic en, input logic init, input logic [1:0] mode,
                             input int d, input int p, input int c);
        cfg_ch     = 4'(ch);
        cfg_en     = en;
        cfg_init   = init;
        cfg_mode   = mode;
        cfg_delay  = CNT_W'(d);
        cfg_period = CNT_W'(p);
        cfg_count  = CNT_W'(c);
        cfg_we     = 1'b1;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        logic e;
        rst_ni = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_init = 1'b0; cfg_mode = '0;
        cfg_delay = '0; cfg_period = '0; cfg_count = '0; start = 1'b0; stop = 1'b0;
        #2;
        check("rst_gpio", gpio, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_alldone", all_done, 0);
        check("rst_mon", mon_cnt, 0);
        #20 rst_ni = 1'b1;
        tick();

        // TOGGLE ch1: init 0, D=0, P=50, 12 events from edge t+51.
        cfg_write(1, 1'b1, 1'b0, 2'd0, 0, 50, 12);
        check("tog_cfg_gpio", gpio[1], 0);
        check("tog_alldone_pre", all_done, 0);
        do_start();
        check("tog_busy", busy, 1);
        bad_k = 0;
        for (int k = 1; k <= 620; k++) begin
            int n;
            tick();
            n = (k >= 51) ? ((k - 51) / 50 + 1) : 0;
            if (n > 12) n = 12;
            if (gpio[1] !== 1'(n % 2) && bad_k == 0) bad_k = k;
            if (k == 50)  check("tog_before_first", gpio[1], 0);
            if (k == 51)  check("tog_first", gpio[1], 1);
            if (k == 600) check("tog_done_early", done[1], 0);
            if (k == 601) check("tog_done_12th", done[1], 1);
        end
        check("tog_wave_first_bad", bad_k, 0);
        check("tog_end_gpio", gpio[1], 0);
        check("tog_alldone", all_done, 1);
        check("tog_busy_end", busy, 0);

        // PULSE ch2: init 1, D=3, P=4, three lows after t+8, t+12, t+16.
        cfg_write(1, 1'b0, 1'b0, 2'd0, 0, 1, 0);
        cfg_write(2, 1'b1, 1'b1, 2'd1, 3, 4, 3);
        check("pul_cfg_gpio", gpio[2], 1);
        do_start();
        bad_k = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            e = (k == 8 || k == 12 || k == 16) ? 1'b0 : 1'b1;
            if (gpio[2] !== e && bad_k == 0) bad_k = k;
            if (k == 8)  check("pul_low_1", gpio[2], 0);
            if (k == 9)  check("pul_back_1", gpio[2], 1);
            if (k == 15) check("pul_done_early", done[2], 0);
            if (k == 16) check("pul_done", done[2], 1);
        end
        check("pul_wave_first_bad", bad_k, 0);
        check("pul_alldone", all_done, 1);

        // count=0 on ch3: DONE after the start edge, no events.
        cfg_write(2, 1'b0, 1'b0, 2'd0, 0, 1, 0);
        cfg_write(3, 1'b1, 1'b0, 2'd0, 2, 2, 0);
        check("cnt0_done_pre", done[3], 0);
        do_start();
        check("cnt0_done", done[3], 1);
        check("cnt0_busy", busy, 0);
        tick(); tick(); tick();
        check("cnt0_gpio", gpio[3], 0);

        // period=0 on ch4: toggles every cycle, events after t+2..t+5.
        cfg_write(3, 1'b0, 1'b0, 2'd0, 0, 1, 0);
        cfg_write(4, 1'b1, 1'b0, 2'd0, 0, 0, 4);
        do_start();
        bad_k = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = (k >= 2 && k <= 5) ? ((k % 2) == 0) : 1'b0;
            if (gpio[4] !== e && bad_k == 0) bad_k = k;
            if (k == 4) check("p0_done_early", done[4], 0);
            if (k == 5) check("p0_done", done[4], 1);
        end
        check("p0_wave_first_bad", bad_k, 0);

        // Stop mid-RUN and a dropped write on ch5: init 1, D=2, P=3, count 10.
        cfg_write(4, 1'b0, 1'b0, 2'd0, 0, 1, 0);
        cfg_write(5, 1'b1, 1'b1, 2'd0, 2, 3, 10);
        do_start();
        for (int k = 1; k <= 7; k++) tick();
        check("stp_first_event", gpio[5], 0);
        check("stp_busy_run", busy, 1);
        cfg_write(5, 1'b1, 1'b0, 2'd0, 0, 10, 1);
        check("blk_write_busy", busy, 1);
        do_stop();
        check("stp_gpio_init", gpio[5], 1);
        check("stp_busy", busy, 0);
        check("stp_done", done[5], 0);
        do_start();
        tick();
        check("replay_s1", gpio[5], 1);
        for (int k = 2; k <= 6; k++) tick();
        check("replay_s6", gpio[5], 0);
        tick();

        // Asynchronous reset while ch5 is running.
        #3 rst_ni = 1'b0;
        #1;
        check("arst_gpio", gpio, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 0);
        check("arst_mon", mon_cnt, 0);
        #3 rst_ni = 1'b1;
        tick();
        do_start();
        tick(); tick(); tick(); tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_gpio", gpio, 0);
        check("post_rst_alldone", all_done, 0);

        // Monitor: ch6 toggles 5 times, looped back into gpio_i.
        cfg_write(6, 1'b1, 1'b0, 2'd0, 0, 2, 5);
        do_start();
        for (int k = 1; k <= 20; k++) tick();
        check("mon_ch6_gpio", gpio[6], 1);
        check("mon_alldone", all_done, 1);
        mon_exp = '0;
`ifdef GPIO_STIM_MON_EN
        mon_exp[6*CNT_W +: CNT_W] = CNT_W'(5);
`endif
        check("mon_cnt", mon_cnt, mon_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
